ift_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one `ift_sram_mem` port between the Kronos instruction and data interfaces, with cell-level taint shadows on every signal. It sits between `kronos_mem_top` and a single unified SRAM, replacing the split instruction ROM / data SRAM pair when one memory image is wanted. It drives per-requester grant and response-valid signals and routes read data back to the owning requester. Taints travel beside data and also through the arbitration decision.

---
 rtl/ift_mem_arb_pkg.sv | 15 +
 rtl/ift_mem_arb_picker.sv | 52 +++++
 rtl/ift_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_ift_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ift_mem_arb_pkg.sv
// rtl/ift_mem_arb_pkg.sv - shared types and constants for the taint-tracking memory arbiter
package ift_mem_arb_pkg;

    localparam int unsigned NumReq = 2;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] strb_t;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_idx_e;

endpackage

// File: rtl/ift_mem_arb_picker.sv
// rtl/ift_mem_arb_picker.sv - 2-way grant selection with priority register and its taint shadow
module ift_mem_arb_picker
    import ift_mem_arb_pkg::*;
#(
    parameter bit RoundRobin = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] req_t0_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [NumReq-1:0] gnt_t0_o,
    output logic              sel_o,
    output logic              sel_t0_o
);

    logic prio_q, prio_d;
    logic prio_t0_q, prio_t0_d;
    logic contended;

    // Pick the winner; on contention the loser gets priority next time.
    always_comb begin
        contended = req_i[REQ_INSTR] & req_i[REQ_DATA];
        if (contended) begin
            sel_o = RoundRobin ? prio_q : REQ_INSTR;
        end else begin
            sel_o = req_i[REQ_DATA];
        end
        gnt_o[REQ_INSTR] = req_i[REQ_INSTR] & (sel_o == REQ_INSTR);
        gnt_o[REQ_DATA]  = req_i[REQ_DATA] & (sel_o == REQ_DATA);

        // The selector depends on both request lines, and on the priority bit when contended.
        sel_t0_o = req_t0_i[REQ_INSTR] | req_t0_i[REQ_DATA]
                 | (contended & RoundRobin & prio_t0_q);
        gnt_t0_o = contended ? {NumReq{sel_t0_o}} : req_t0_i;

        prio_d    = contended ? ~sel_o : prio_q;
        prio_t0_d = contended ? sel_t0_o : prio_t0_q;
    end

    // Priority register and its taint shadow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= 1'b0;
            prio_t0_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            prio_t0_q <= prio_t0_d;
        end
    end

endmodule

// File: rtl/ift_mem_arbiter.sv
// rtl/ift_mem_arbiter.sv - instr/data arbiter onto one SRAM port with bit-precise taint shadows
module ift_mem_arbiter
    import ift_mem_arb_pkg::*;
#(
    parameter int unsigned NumTaints  = 1,
    parameter bit          RoundRobin = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq-1:0]       req_i_t0,
    input  logic [NumReq-1:0]       we_i,
    input  logic [NumReq-1:0]       we_i_t0,
    input  logic [NumReq-1:0][31:0] addr_i,
    input  logic [NumReq-1:0][31:0] addr_i_t0,
    input  logic [NumReq-1:0][31:0] wdata_i,
    input  logic [NumReq-1:0][31:0] wdata_i_t0,
    input  logic [NumReq-1:0][31:0] strb_i,
    input  logic [NumReq-1:0][31:0] strb_i_t0,
    output logic [NumReq-1:0]       gnt_o,
    output logic [NumReq-1:0]       gnt_o_t0,
    output logic [NumReq-1:0]       rvalid_o,
    output logic [NumReq-1:0]       rvalid_o_t0,
    output logic [NumReq-1:0][31:0] rdata_o,
    output logic [NumReq-1:0][31:0] rdata_o_t0,
    output logic                    mem_req_o,
    output logic                    mem_req_o_t0,
    output logic                    mem_we_o,
    output logic                    mem_we_o_t0,
    output logic [31:0]             mem_addr_o,
    output logic [31:0]             mem_addr_o_t0,
    output logic [31:0]             mem_wdata_o,
    output logic [31:0]             mem_wdata_o_t0,
    output logic [31:0]             mem_strb_o,
    output logic [31:0]             mem_strb_o_t0,
    input  logic [31:0]             mem_rdata_i,
    input  logic [31:0]             mem_rdata_i_t0
);

    // A zero taint width switches shadow tracking off entirely.
    localparam bit TaintOn = (NumTaints != 0);

    logic [NumReq-1:0] req_t0, we_t0;
    logic [NumReq-1:0][31:0] addr_t0, wdata_t0, strb_t0;
    data_t rdata_t0;
    logic sel, sel_t0, pay_live;

    logic rsp_valid_q, rsp_valid_d;
    logic rsp_owner_q, rsp_owner_d;
    logic rsp_we_q, rsp_we_d;
    logic rsp_valid_t0_q, rsp_valid_t0_d;
    logic rsp_owner_t0_q, rsp_owner_t0_d;

    // Input taints, gated by the tracking enable.
    always_comb begin
        req_t0   = TaintOn ? req_i_t0 : '0;
        we_t0    = TaintOn ? we_i_t0 : '0;
        addr_t0  = TaintOn ? addr_i_t0 : '0;
        wdata_t0 = TaintOn ? wdata_i_t0 : '0;
        strb_t0  = TaintOn ? strb_i_t0 : '0;
        rdata_t0 = TaintOn ? mem_rdata_i_t0 : '0;
    end

    ift_mem_arb_picker #(
        .RoundRobin(RoundRobin)
    ) u_picker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .req_t0_i(req_t0),
        .gnt_o   (gnt_o),
        .gnt_t0_o(gnt_o_t0),
        .sel_o   (sel),
        .sel_t0_o(sel_t0)
    );

    // Route the winner's payload to memory; idle cycles drive zeros.
    always_comb begin
        mem_req_o    = |gnt_o;
        // OR of the two requests is tainted only if no untainted asserted request pins it high.
        mem_req_o_t0 = (req_t0[0] & req_t0[1]) | (req_t0[0] & ~req_i[1]) | (req_t0[1] & ~req_i[0]);
        pay_live     = mem_req_o | mem_req_o_t0;

        mem_we_o    = mem_req_o ? we_i[sel] : 1'b0;
        mem_addr_o  = mem_req_o ? (addr_i[sel] >> 2) : '0;
        mem_wdata_o = mem_req_o ? wdata_i[sel] : '0;
        mem_strb_o  = mem_req_o ? strb_i[sel] : '0;

        mem_we_o_t0    = pay_live ? (we_t0[sel] | sel_t0) : 1'b0;
        mem_addr_o_t0  = pay_live ? ((addr_t0[sel] >> 2) | {32{sel_t0}}) : '0;
        mem_wdata_o_t0 = pay_live ? (wdata_t0[sel] | {32{sel_t0}}) : '0;
        mem_strb_o_t0  = pay_live ? (strb_t0[sel] | {32{sel_t0}}) : '0;
    end

    // Remember who owns the access now in flight.
    always_comb begin
        rsp_valid_d    = mem_req_o;
        rsp_owner_d    = sel;
        rsp_we_d       = mem_we_o;
        rsp_valid_t0_d = mem_req_o_t0;
        rsp_owner_t0_d = sel_t0;
    end

    // Response tracker registers; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q    <= 1'b0;
            rsp_owner_q    <= 1'b0;
            rsp_we_q       <= 1'b0;
            rsp_valid_t0_q <= 1'b0;
            rsp_owner_t0_q <= 1'b0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_owner_q    <= rsp_owner_d;
            rsp_we_q       <= rsp_we_d;
            rsp_valid_t0_q <= rsp_valid_t0_d;
            rsp_owner_t0_q <= rsp_owner_t0_d;
        end
    end

    // Steer the SRAM response to its owner; writes return valid with zero data.
    always_comb begin
        rvalid_o    = '0;
        rvalid_o_t0 = '0;
        rdata_o     = '0;
        rdata_o_t0  = '0;
        for (int i = 0; i < NumReq; i++) begin
            rvalid_o[i]    = rsp_valid_q & (rsp_owner_q == 1'(i));
            rvalid_o_t0[i] = rsp_valid_t0_q | rsp_owner_t0_q;
            rdata_o[i]     = (rsp_valid_q & (rsp_owner_q == 1'(i)) & ~rsp_we_q) ? mem_rdata_i : '0;
            rdata_o_t0[i]  = ((rsp_valid_q & (rsp_owner_q == 1'(i)) & ~rsp_we_q) ? rdata_t0 : '0)
                           | {32{rsp_owner_t0_q & rsp_valid_q}};
        end
    end

endmodule

// File: tb/tb_ift_mem_arbiter.sv
// tb/tb_ift_mem_arbiter.sv - self-checking bench for ift_mem_arbiter
module tb_ift_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req, req_t0, we, we_t0;
    logic [1:0][31:0] addr, addr_t0, wdata, wdata_t0, strb, strb_t0;
    logic [31:0] rdata_drv, mem_rdata, mem_rdata_t0;

    logic [1:0] gnt, gnt_t0, rvalid, rvalid_t0;
    logic [1:0][31:0] rdata, rdata_t0;
    logic m_req, m_req_t0, m_we, m_we_t0;
    logic [31:0] m_addr, m_addr_t0, m_wdata, m_wdata_t0, m_strb, m_strb_t0;

    logic [1:0] gnt_f, gnt_t0_f, rvalid_f, rvalid_t0_f;
    logic [1:0][31:0] rdata_f, rdata_t0_f;
    logic m_req_f, m_req_t0_f, m_we_f, m_we_t0_f;
    logic [31:0] m_addr_f, m_addr_t0_f, m_wdata_f, m_wdata_t0_f, m_strb_f, m_strb_t0_f;

    int errors = 0;
    int checks = 0;

    // Small behavioural SRAM used by the write-then-read scenario.
    bit sram_en = 1'b0;
    logic [31:0] sram [0:15];
    logic [31:0] sram_q = '0;
    always @(posedge clk) begin
        if (sram_en && m_req) begin
            if (m_we) sram[m_addr[3:0]] <= (sram[m_addr[3:0]] & ~m_strb) | (m_wdata & m_strb);
            else sram_q <= sram[m_addr[3:0]];
        end
    end
    assign mem_rdata = sram_en ? sram_q : rdata_drv;

    ift_mem_arbiter #(.NumTaints(1), .RoundRobin(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
        .addr_i(addr), .addr_i_t0(addr_t0), .wdata_i(wdata), .wdata_i_t0(wdata_t0),
        .strb_i(strb), .strb_i_t0(strb_t0),
        .gnt_o(gnt), .gnt_o_t0(gnt_t0), .rvalid_o(rvalid), .rvalid_o_t0(rvalid_t0),
        .rdata_o(rdata), .rdata_o_t0(rdata_t0),
        .mem_req_o(m_req), .mem_req_o_t0(m_req_t0), .mem_we_o(m_we), .mem_we_o_t0(m_we_t0),
        .mem_addr_o(m_addr), .mem_addr_o_t0(m_addr_t0), .mem_wdata_o(m_wdata), .mem_wdata_o_t0(m_wdata_t0),
        .mem_strb_o(m_strb), .mem_strb_o_t0(m_strb_t0),
        .mem_rdata_i(mem_rdata), .mem_rdata_i_t0(mem_rdata_t0)
    );

    ift_mem_arbiter #(.NumTaints(1), .RoundRobin(1'b0)) dut_fixed (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .req_i_t0(req_t0), .we_i(we), .we_i_t0(we_t0),
        .addr_i(addr), .addr_i_t0(addr_t0), .wdata_i(wdata), .wdata_i_t0(wdata_t0),
        .strb_i(strb), .strb_i_t0(strb_t0),
        .gnt_o(gnt_f), .gnt_o_t0(gnt_t0_f), .rvalid_o(rvalid_f), .rvalid_o_t0(rvalid_t0_f),
        .rdata_o(rdata_f), .rdata_o_t0(rdata_t0_f),
        .mem_req_o(m_req_f), .mem_req_o_t0(m_req_t0_f), .mem_we_o(m_we_f), .mem_we_o_t0(m_we_t0_f),
        .mem_addr_o(m_addr_f), .mem_addr_o_t0(m_addr_t0_f), .mem_wdata_o(m_wdata_f), .mem_wdata_o_t0(m_wdata_t0_f),
        .mem_strb_o(m_strb_f), .mem_strb_o_t0(m_strb_t0_f),
        .mem_rdata_i(mem_rdata), .mem_rdata_i_t0(mem_rdata_t0)
    );

    task automatic idle();
        req = '0; req_t0 = '0; we = '0; we_t0 = '0;
        addr = '0; addr_t0 = '0; wdata = '0; wdata_t0 = '0; strb = '0; strb_t0 = '0;
        rdata_drv = '0; mem_rdata_t0 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({gnt, rvalid, m_req, m_we} !== 6'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", {gnt, rvalid, m_req, m_we}); end
        checks++; if ({rdata, m_addr, m_wdata, m_strb} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {rdata, m_addr, m_wdata, m_strb}); end
        checks++; if ({gnt_t0, rvalid_t0, m_req_t0, m_we_t0, rdata_t0, m_addr_t0, m_wdata_t0, m_strb_t0} !== '0) begin
            errors++; $display("FAIL reset_taint got=%h exp=0", {gnt_t0, rvalid_t0, m_req_t0, m_we_t0, rdata_t0, m_addr_t0, m_wdata_t0, m_strb_t0});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_instr_read();
        req = 2'b01; addr[0] = 32'h8000_0010;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ird_gnt got=%b exp=01", gnt); end
        checks++; if (m_addr !== 32'h2000_0004) begin errors++; $display("FAIL ird_addr got=%h exp=20000004", m_addr); end
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL ird_memreq got=%b exp=1", m_req); end
        step();
        idle(); rdata_drv = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL ird_rvalid got=%b exp=01", rvalid); end
        checks++; if (rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ird_rdata0 got=%h exp=deadbeef", rdata[0]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL ird_rdata1 got=%h exp=0", rdata[1]); end
        step();
        idle();
        step();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++) begin
            req = 2'b11; addr[0] = $urandom; addr[1] = $urandom;
            @(negedge clk);
            checks++; if (gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, (k % 2 == 0) ? 2'b01 : 2'b10); end
            checks++; if (gnt_f !== 2'b01) begin errors++; $display("FAIL fixed_gnt k=%0d got=%b exp=01", k, gnt_f); end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 16; i++) sram[i] = '0;
        sram_en = 1'b1;
        req = 2'b10; we = 2'b10; addr[1] = 32'h0000_0040; wdata[1] = 32'h1234_5678; strb[1] = '1;
        @(negedge clk);
        checks++; if (gnt !== 2'b10 || m_we !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b/%b exp=10/1", gnt, m_we); end
        step();
        idle(); req = 2'b01; addr[0] = 32'h0000_0040;
        @(negedge clk);
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL wr_rvalid got=%b exp=10", rvalid); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL wr_rdata1 got=%h exp=0", rdata[1]); end
        step();
        idle();
        @(negedge clk);
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL rd_rvalid got=%b exp=01", rvalid); end
        checks++; if (rdata[0] !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata0 got=%h exp=12345678", rdata[0]); end
        step();
        sram_en = 1'b0;
    endtask

    // Reference model: winner from the request pattern and a priority flag, plus one pending response.
    task automatic test_random(input int n);
        bit mprio = 1'b0;
        bit pend_v = 1'b0, pend_o = 1'b0, pend_we = 1'b0;
        bit any, w, wf;
        logic [1:0] exp_gnt, exp_rv;
        logic [31:0] exp_rd0, exp_rd1;
        for (int c = 0; c < n; c++) begin
            req = 2'($urandom_range(0, 3)); we = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                addr[i] = $urandom; wdata[i] = $urandom; strb[i] = $urandom;
            end
            rdata_drv = $urandom;
            @(negedge clk);
            any = (req != 2'b00);
            if (req == 2'b11) w = mprio;
            else w = (req == 2'b10);
            wf = (req == 2'b10);
            exp_gnt = any ? (w ? 2'b10 : 2'b01) : 2'b00;
            exp_rv  = pend_v ? (pend_o ? 2'b10 : 2'b01) : 2'b00;
            exp_rd0 = (pend_v && !pend_o && !pend_we) ? rdata_drv : 32'h0;
            exp_rd1 = (pend_v && pend_o && !pend_we) ? rdata_drv : 32'h0;
            checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
            checks++; if (gnt_f !== (any ? (wf ? 2'b10 : 2'b01) : 2'b00)) begin errors++; $display("FAIL rnd_gnt_fixed c=%0d got=%b", c, gnt_f); end
            checks++; if (m_req !== any) begin errors++; $display("FAIL rnd_memreq c=%0d got=%b exp=%b", c, m_req, any); end
            checks++; if (m_addr !== (any ? addr[w] >> 2 : 32'h0)) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, m_addr, any ? addr[w] >> 2 : 32'h0); end
            checks++; if ({m_we, m_wdata, m_strb} !== (any ? {we[w], wdata[w], strb[w]} : 65'h0)) begin
                errors++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, {m_we, m_wdata, m_strb}, any ? {we[w], wdata[w], strb[w]} : 65'h0);
            end
            checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, rvalid, exp_rv); end
            checks++; if (rdata[0] !== exp_rd0 || rdata[1] !== exp_rd1) begin
                errors++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, rdata[0], rdata[1], exp_rd0, exp_rd1);
            end
            checks++; if ({gnt_t0, rvalid_t0, m_req_t0, m_addr_t0, rdata_t0} !== '0) begin errors++; $display("FAIL rnd_taint c=%0d got nonzero exp=0", c); end
            if (req == 2'b11) mprio = ~w;
            pend_v = any; pend_o = w; pend_we = any && we[w];
            step();
        end
        idle();
        step();
    endtask

    task automatic test_taint_contention();
        req = 2'b11; req_t0 = 2'b10; addr[0] = $urandom; addr[1] = $urandom;
        @(negedge clk);
        checks++; if (gnt_t0 !== 2'b11) begin errors++; $display("FAIL tc_gnt_t0 got=%b exp=11", gnt_t0); end
        checks++; if (m_addr_t0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tc_addr_t0 got=%h exp=ffffffff", m_addr_t0); end
        checks++; if (m_req_t0 !== 1'b0) begin errors++; $display("FAIL tc_req_t0 got=%b exp=0", m_req_t0); end
        step();
        idle();
        @(negedge clk);
        checks++; if (rvalid_t0 !== 2'b11) begin errors++; $display("FAIL tc_rvalid_t0 got=%b exp=11", rvalid_t0); end
        step();
    endtask

    task automatic test_rdata_taint();
        idle(); req = 2'b01;
        step();
        idle(); mem_rdata_t0 = 32'h0000_00FF;
        @(negedge clk);
        checks++; if (rdata_t0[0] !== 32'h0000_00FF) begin errors++; $display("FAIL rt_rdata_t0_0 got=%h exp=000000ff", rdata_t0[0]); end
        checks++; if (rdata_t0[1] !== 32'h0) begin errors++; $display("FAIL rt_rdata_t0_1 got=%h exp=0", rdata_t0[1]); end
        step();
        idle();
    endtask

    task automatic test_reset_midflight();
        bit got0 = 1'b0;
        for (int k = 0; k < 3 && !got0; k++) begin
            req = 2'b11;
            @(negedge clk);
            got0 = (gnt == 2'b01);
            step();
        end
        checks++; if (!got0) begin errors++; $display("FAIL rm_setup got=no instr grant in 3 cycles exp=grant"); end
        idle();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rm_rvalid got=%b exp=00", rvalid); end
        checks++; if (rvalid_t0 !== 2'b00) begin errors++; $display("FAIL rm_rvalid_t0 got=%b exp=00", rvalid_t0); end
        step();
        req = 2'b11;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_prio got=%b exp=01", gnt); end
        step();
        idle();
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_instr_read();
        test_round_robin();
        test_write_read();
        test_random(300);
        test_taint_contention();
        test_rdata_taint();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
